// File: rtl/sad.sv
// sad: 8x8 block sum-of-absolute-differences engine with a 3-stage pipeline.
// Define SAD_VALID_OUT_EN to add the sad_valid result strobe.
module sad #(
    parameter int PIX_W = 8,
    parameter int PIX_N = 8,
    parameter int ROWS  = 8,
    parameter int SAD_W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   crt_keep,
    input  logic [PIX_N*PIX_W-1:0] pre_frame,
    input  logic [PIX_N*PIX_W-1:0] crt_frame,
`ifdef SAD_VALID_OUT_EN
    output logic                   sad_valid,
`endif
    output logic [SAD_W-1:0]       sad_data
);
    localparam int RS_W  = PIX_W + $clog2(PIX_N);
    localparam int CNT_W = ROWS > 1 ? $clog2(ROWS) : 1;

    logic [PIX_W-1:0] diff_c [PIX_N];
    logic [PIX_W-1:0] diff   [PIX_N];
    logic [RS_W-1:0]  sum_c;
    logic [RS_W-1:0]  row_sum;
    logic [SAD_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             v1;
    logic             v2;
    logic             last;

    for (genvar i = 0; i < PIX_N; i++) begin : g_diff
        logic [PIX_W-1:0] p;
        logic [PIX_W-1:0] c;
        assign p = pre_frame[i*PIX_W +: PIX_W];
        assign c = crt_frame[i*PIX_W +: PIX_W];
        assign diff_c[i] = p > c ? p - c : c - p;
    end

    always_comb begin
        sum_c = '0;
        for (int j = 0; j < PIX_N; j++) sum_c = sum_c + RS_W'(diff[j]);
    end

    assign last = cnt == CNT_W'(ROWS - 1);

    // Frame inputs are captured only on valid rows so bubble-cycle garbage never enters the pipe.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            diff     <= '{default: '0};
            v1       <= 1'b0;
            v2       <= 1'b0;
            row_sum  <= '0;
            acc      <= '0;
            cnt      <= '0;
            sad_data <= '0;
        end else begin
            if (crt_keep) diff <= diff_c;
            v1      <= crt_keep;
            v2      <= v1;
            row_sum <= sum_c;
            if (v2) begin
                cnt <= last ? '0 : cnt + 1'b1;
                acc <= last ? '0 : acc + SAD_W'(row_sum);
                if (last) sad_data <= acc + SAD_W'(row_sum);
            end
        end
    end

`ifdef SAD_VALID_OUT_EN
    always_ff @(posedge clk) begin
        if (rst_n) sad_valid <= 1'b0;
        else sad_valid <= v2 && last;
    end
`endif
endmodule

// File: tb/tb_sad.sv
// tb_sad: table-driven block vectors with a due-cycle scoreboard for sad.
module tb_sad;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        crt_keep = 1'b0;
    logic [63:0] pre_frame = '0;
    logic [63:0] crt_frame = '0;
    logic [13:0] sad_data;
`ifdef SAD_VALID_OUT_EN
    logic        sad_valid;
`endif

    sad dut (
        .clk(clk),
        .rst_n(rst_n),
        .crt_keep(crt_keep),
        .pre_frame(pre_frame),
        .crt_frame(crt_frame),
`ifdef SAD_VALID_OUT_EN
        .sad_valid(sad_valid),
`endif
        .sad_data(sad_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [13:0] val;
        bit          blk;
    } exp_t;

    typedef struct {
        logic [63:0] pre;
        logic [63:0] crt;
        bit          bub;
        logic [13:0] exp;
    } tv_t;

    exp_t        q[$];
    int          e = 0;
    int          tests = 0;
    int          fails = 0;
    bit          armed = 0;
    logic [13:0] cur = '0;

    always @(posedge clk) e <= e + 1;

    // Expected results become current at their due cycle; sad_data must hold in between.
    always @(negedge clk) begin
        bit vexp;
        vexp = 0;
        if (q.size() != 0 && q[0].due == e) begin
            cur = q[0].val;
            vexp = q[0].blk;
            armed = 1;
            void'(q.pop_front());
        end
        if (armed) begin
            tests++;
            if (sad_data !== cur) begin
                fails++;
                $display("FAIL sad_data cyc=%0d got=%0d exp=%0d", e, sad_data, cur);
            end
`ifdef SAD_VALID_OUT_EN
            tests++;
            if (sad_valid !== vexp) begin
                fails++;
                $display("FAIL sad_valid cyc=%0d got=%0b exp=%0b", e, sad_valid, vexp);
            end
`endif
        end
    end

    task automatic step(input logic r, input logic k, input logic [63:0] p, input logic [63:0] c);
        if (r) begin
            while (q.size() != 0 && q[$].due > e) void'(q.pop_back());
            q.push_back('{due: e + 1, val: 14'd0, blk: 0});
        end
        rst_n = r;
        crt_keep = k;
        pre_frame = p;
        crt_frame = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic run_block(input tv_t t);
        for (int r = 0; r < 8; r++) begin
            step(1'b0, 1'b1, t.pre, t.crt);
            if (r == 7) q.push_back('{due: e + 2, val: t.exp, blk: 1});
            if (t.bub) step(1'b0, 1'b0, rnd64(), rnd64());
        end
    endtask

    tv_t tv[7];

    initial begin
        tv[0] = '{pre: 64'hFFFF_FFFF_FFFF_FFFF, crt: 64'h0, bub: 0, exp: 14'd16320};
        tv[1] = '{pre: 64'hFFFF_FFFF_FFFF_FFFF, crt: 64'h0, bub: 0, exp: 14'd16320};
        tv[2] = '{pre: 64'h0, crt: 64'hFFFF_FFFF_FFFF_FFFF, bub: 0, exp: 14'd16320};
        tv[3] = '{pre: 64'h0123456789ABCDEF, crt: 64'h0123456789ABCDEF, bub: 0, exp: 14'd0};
        tv[4] = '{pre: {8'd1, 8'd128, 8'd50, 8'd50, 8'd255, 8'd0, 8'd200, 8'd10},
                  crt: {8'd2, 8'd127, 8'd40, 8'd60, 8'd0, 8'd0, 8'd100, 8'd20},
                  bub: 0, exp: 14'd3096};
        tv[5] = '{pre: 64'hFFFF_FFFF_FFFF_FFFF, crt: 64'h0, bub: 1, exp: 14'd16320};
        tv[6] = '{pre: 64'h0101_0101_0101_0101, crt: 64'h0, bub: 0, exp: 14'd64};
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd64(), rnd64());
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, rnd64(), rnd64());
        for (int i = 0; i < 7; i++) run_block(tv[i]);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        step(1'b1, 1'b1, rnd64(), rnd64());
        run_block(tv[6]);
        run_block(tv[4]);
        for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 1'b0, rnd64(), rnd64());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, rnd64(), rnd64());
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sad.md
Name: sad

Overview:
- Sum-of-absolute-differences engine for 8x8-pixel block motion estimation.
- Each valid cycle it takes one 8-pixel row from the previous frame (candidate) and one from the current frame. Over 8 valid rows it accumulates the absolute pixel differences and presents the block SAD on sad_data.
- Sits between the frame-buffer row fetch and the motion-vector compare/min logic.

Parameters:
- PIX_W, 8, bits per pixel (unsigned luma).
- PIX_N, 8, pixels per row; pre_frame/crt_frame width = PIX_N*PIX_W.
- ROWS, 8, valid rows per block.
- SAD_W, 14, result width; must satisfy SAD_W >= ceil(log2(PIX_N*ROWS*(2^PIX_W-1)+1)). Default maximum is 16320.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-high despite the name; sampled on rising clk.
- crt_keep  input  1  row-valid qualifier; high = pre_frame/crt_frame hold a valid row this cycle.
- pre_frame  input  64  previous-frame row; pixel i = bits [i*8+7 : i*8].
- crt_frame  input  64  current-frame row, same packing.
- sad_data  output  14  registered SAD of the most recently completed 8x8 block.

Behaviour:
- Reset (rst_n=1 at a rising edge): every register is cleared to 0, including pipeline, row counter, accumulator, pipeline valids and sad_data. Reset has priority over all other activity. Reset mid-block discards the partial block; the next valid row becomes row 0.
- Stage 1, at the edge where crt_keep=1:
  - register |pre_i - crt_i| for each of the 8 pixels (8-bit unsigned, computed as larger minus smaller, no sign wrap);
  - register v1=crt_keep.
- Stage 2: register row_sum = sum of the 8 diffs (11 bits, max 2040) and v2=v1.
- Stage 3, when v2=1:
  - row counter 0..7 increments;
  - if counter<7: acc <= acc + row_sum;
  - if counter==7: sad_data <= acc + row_sum, acc <= 0, counter wraps to 0.
- sad_data changes only on block completion and holds its value otherwise.
- Latency: row sampled at edge E; its contribution reaches stage 3 at edge E+2. A block whose 8th row is sampled at edge E shows its result on sad_data after edge E+2.
- crt_keep=0 cycles are bubbles: no contribution, counter and acc hold. Rows of a block need not be contiguous.
- Back-to-back blocks with crt_keep held high produce a new result every 8 cycles, with no dead cycle.
- Arithmetic is unsigned throughout. The accumulator is SAD_W bits and cannot overflow under the width rule above.
- Inputs are only sampled when crt_keep=1. X on frame inputs while crt_keep=0 must not propagate.

Optional Feature:
- Macro SAD_VALID_OUT_EN.
- When defined: add output sad_valid (1 bit, reset 0). It is a one-cycle pulse asserted in the cycle after the edge where sad_data is updated, i.e. coincident with the new sad_data value.
- When undefined: port absent; downstream counts 8 valid rows plus 2 cycles of latency itself.
- sad_data behaviour is identical either way.

Test Plan:
- Reset hold: rst_n=1 for 3 cycles with random frames and crt_keep=1 -> sad_data=0. After release with crt_keep=0 for 8 cycles -> sad_data stays 0.
- Max difference: pre_frame=64'hFFFF_FFFF_FFFF_FFFF, crt_frame=0, crt_keep rises and stays high -> sad_data=16320 (14'h3FC0) appears 2 edges after the 8th sampled row. It stays 16320 across subsequent blocks; sad_valid (if enabled) pulses every 8 cycles.
- Sign symmetry: pre=0, crt=all 0xFF -> 16320. Then pre=crt=64'h0123456789ABCDEF for 8 rows -> 0.
- Mixed pixels: pre bytes {10,200,0,255,50,50,128,1}, crt bytes {20,100,0,0,60,40,127,2}, 8 rows -> row sum 10+100+0+255+10+10+1+1=387, block SAD=3096.
- Bubbles: same row as the max-difference test with crt_keep toggling 1,0,1,0,... -> result 16320 only after the 8th high cycle. sad_data is unchanged in between.
- Mid-block reset: 5 valid rows of max difference, then 1-cycle reset, then 8 valid rows of pre=0x01 bytes vs crt=0 -> sad_data=64 with no contribution from the aborted block.
